// File: rtl/xc20xx_clb_cfgload.sv
// Serial configuration loader for one XC20XX CLB: preamble/length/trailer parse, framed data commit.
// Optional per-frame even parity bit enabled by defining XC20XX_CFGLOAD_PARITY_EN.
module xc20xx_clb_cfgload #(
  parameter int FRAME_W    = 8,
  parameter int NUM_FRAMES = 4,
  parameter int LEN_W      = 12
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               DIN,
  input  logic                               DIN_VALID,
  output logic [FRAME_W*NUM_FRAMES-1:0]      CFG,
  output logic                               DONE,
  output logic                               ERR,
  output logic [$clog2(NUM_FRAMES+1)-1:0]    FRAME_IDX
);

  localparam int IDX_W   = $clog2(NUM_FRAMES+1);
  localparam int CNT_MAX = (LEN_W > FRAME_W) ? LEN_W : FRAME_W;
  localparam int CNT_W   = $clog2(CNT_MAX+1);
`ifdef XC20XX_CFGLOAD_PARITY_EN
  localparam int FRAME_BITS = FRAME_W + 5;
`else
  localparam int FRAME_BITS = FRAME_W + 4;
`endif
  localparam logic [LEN_W-1:0] EXP_LEN  = LEN_W'(NUM_FRAMES*FRAME_BITS);
  localparam logic [7:0]       PREAMBLE = 8'b1111_0010;

  typedef enum logic [3:0] {
    HUNT,
    LENGTH,
    TRAIL,
    START,
    DATA,
`ifdef XC20XX_CFGLOAD_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE_ST,
    ERR_ST
  } state_t;

  state_t             state;
  logic [7:0]         window;
  logic [LEN_W-1:0]   len_sh;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] frame_buf;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= HUNT;
      CFG       <= '0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      FRAME_IDX <= '0;
      window    <= '0;
      len_sh    <= '0;
      cnt       <= '0;
    end else if (DIN_VALID) begin
      case (state)
        HUNT: begin
          window <= {window[6:0], DIN};
          if ({window[6:0], DIN} == PREAMBLE) begin
            state <= LENGTH;
            cnt   <= '0;
          end
        end
        LENGTH: begin
          len_sh <= {len_sh[LEN_W-2:0], DIN};
          if (cnt == CNT_W'(LEN_W-1)) begin
            cnt <= '0;
            if ({len_sh[LEN_W-2:0], DIN} == EXP_LEN) begin
              state <= TRAIL;
            end else begin
              state <= ERR_ST;
              ERR   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TRAIL: begin
          if (!DIN) begin
            state <= ERR_ST;
            ERR   <= 1'b1;
          end else if (cnt == CNT_W'(3)) begin
            cnt   <= '0;
            state <= START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        START: begin
          cnt <= '0;
          if (DIN) begin
            state <= ERR_ST;
            ERR   <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          frame_buf <= {frame_buf[FRAME_W-2:0], DIN};
          if (cnt == CNT_W'(FRAME_W-1)) begin
            cnt <= '0;
`ifdef XC20XX_CFGLOAD_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef XC20XX_CFGLOAD_PARITY_EN
        PARITY: begin
          // Even parity across the data bits and the parity bit itself.
          if (^{frame_buf, DIN}) begin
            state <= ERR_ST;
            ERR   <= 1'b1;
          end else begin
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (!DIN) begin
            state <= ERR_ST;
            ERR   <= 1'b1;
          end else if (cnt == CNT_W'(2)) begin
            cnt <= '0;
            // Commit only a fully framed byte so CFG never shows a partial frame.
            for (int f = 0; f < NUM_FRAMES; f++) begin
              if (FRAME_IDX == IDX_W'(f)) CFG[f*FRAME_W +: FRAME_W] <= frame_buf;
            end
            FRAME_IDX <= FRAME_IDX + 1'b1;
            if (FRAME_IDX == IDX_W'(NUM_FRAMES-1)) begin
              state <= DONE_ST;
              DONE  <= 1'b1;
            end else begin
              state <= START;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE_ST: state <= DONE_ST;
        ERR_ST:  state <= ERR_ST;
        default: begin
          state <= ERR_ST;
          ERR   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/xc20xx_clb_cfgload.md
Name: xc20xx_clb_cfgload

Overview:
- Serial configuration loader for one XC20XX CLB. It is the upstream stage that produces the static config bits for the CLB storage-element and logic muxes (S/CLK/POL/R/mode selects, LUT contents).
- Parses an XC2064-style bitstream: preamble, length count, trailer, then framed data with start/stop bits. Commits each good frame into a parallel config register and flags DONE or ERR.

Parameters:
- FRAME_W, 8, data bits per frame.
- NUM_FRAMES, 4, frames per CLB; CFG width = FRAME_W*NUM_FRAMES.
- LEN_W, 12, width of the length-count field.

Ports:
- CLK  input  1  configuration clock (CCLK); all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- DIN  input  1  serial bitstream data.
- DIN_VALID  input  1  DIN sampled only on cycles where DIN_VALID=1; otherwise no state change.
- CFG  output  FRAME_W*NUM_FRAMES  committed config bits.
- DONE  output  1  all frames loaded.
- ERR  output  1  format error detected.
- FRAME_IDX  output  clog2(NUM_FRAMES+1)  number of frames committed so far.

Behaviour:
- Reset (RST=1 at an edge, any state, including mid-frame) sets state=HUNT, CFG=0, DONE=0, ERR=0, FRAME_IDX=0, and clears the preamble window, length and bit counters. RST has priority over DIN_VALID.
- All transitions below occur only on accepted bits (DIN_VALID=1). Outputs are registered, so effects are visible the cycle after the accepted bit.
- HUNT: shift DIN into an 8-bit window (new bit at LSB). When the window after the shift equals 8'b1111_0010, go to LENGTH. Leading zeros or extra ones never cause an error.
- LENGTH: capture LEN_W bits MSB-first. After the last bit, compare with EXP_LEN = NUM_FRAMES*(FRAME_W+4). Match -> TRAIL; mismatch -> ERR.
- TRAIL: expect 4 ones. Any 0 -> ERR. After the 4th one -> START.
- START: expect 0 -> DATA; a 1 -> ERR.
- DATA: shift FRAME_W bits MSB-first into the frame buffer (first bit lands in bit FRAME_W-1) -> STOP.
- STOP: expect 3 ones. Any 0 -> ERR, and the frame is not committed. On the 3rd one:
  - write the frame buffer into CFG[FRAME_IDX*FRAME_W +: FRAME_W] and increment FRAME_IDX;
  - if this was frame NUM_FRAMES-1, go to DONE_ST with DONE=1 in the same cycle CFG updates; else go to START.
- DONE_ST: DONE stays 1; all further bits are ignored; CFG is frozen until RST.
- ERR_ST: ERR stays 1 (sticky), DONE=0; input is ignored; frames already committed remain in CFG; exit only via RST.
- Partial loads: CFG slices for uncommitted frames stay 0. CFG never shows a partially shifted frame.
- DIN_VALID=0 in any state, including mid-field: counters and state hold; no timeout.

Optional Feature:
- Macro XC20XX_CFGLOAD_PARITY_EN.
- Defined:
  - DATA is followed by a PARITY state taking one bit.
  - Even parity over the FRAME_W data bits plus the parity bit is required; failure -> ERR with no commit.
  - EXP_LEN = NUM_FRAMES*(FRAME_W+5).
- Undefined: no parity bit, EXP_LEN = NUM_FRAMES*(FRAME_W+4), no parity logic is synthesised.

Test Plan:
- Nominal load (defaults, no parity):
  - Stimulus: 1111_0010, length 12'h030, 1111, then frames 0,A5,111 / 0,3C,111 / 0,0F,111 / 0,81,111, DIN_VALID=1 throughout.
  - Response: CFG=32'h810F3CA5; DONE=1 the cycle after the 72nd bit; FRAME_IDX=4; ERR=0.
- Gapped valid:
  - Stimulus: same stream with DIN_VALID=0 on every other cycle, plus 5 junk DIN toggles during the gaps.
  - Response: identical final CFG and DONE.
- Bad length:
  - Stimulus: length 12'h031.
  - Response: ERR=1 after the last length bit; CFG=0; DONE=0; later bits ignored.
- Bad stop bit:
  - Stimulus: frame 2 stop bits are 101.
  - Response: ERR=1; CFG=32'h00003CA5; FRAME_IDX=2.
- Reset mid-frame:
  - Stimulus: RST pulse for 1 cycle during frame 1 DATA, then the full nominal stream.
  - Response: CFG=0 immediately after reset; final CFG=32'h810F3CA5; DONE=1.
- Parity (with XC20XX_CFGLOAD_PARITY_EN):
  - Stimulus: length 12'h034, frame A5 followed by parity bit 0.
  - Response: frame accepted.
  - Stimulus: same frame with parity bit 1.
  - Response: ERR=1, frame not committed.
